benes8_cfg_sched: RTL and testbench
===================================

Name: benes8_cfg_sched

Overview:
- Configuration scheduler for the 8-port Benes routing engine.
- Accepts permutation requests from NREQ requesters and arbitrates them round-robin.
- Checks that each request is a true bijection, launches the routing engine, and captures its 20-bit switch-state word into a shadow register.
- Commits the shadow word to the live fabric configuration only on a frame boundary, so the fabric never switches mid-frame.

Parameters:
- NREQ, 2, number of requesters (1..4).
- TIMEOUT, 15, max cycles from engine start to eng_done before abort.
- CFG_W, 20, switch-state word width (fixed by the 8-port fabric).

Ports:
- clk  in  1  clock, all logic on rising edge.
- areset  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_perm  in  NREQ*24  per-requester permutation; entry k = bits [3k+2:3k] = destination of input k.
- req_ready  out  NREQ  one-hot accept; a transfer occurs when valid and ready are both high.
- eng_start  out  1  one-cycle start pulse to the routing engine.
- eng_perm  out  24  permutation presented to the engine; stable from launch until done or abort.
- eng_done  in  1  engine finished; eng_state is valid in the same cycle.
- eng_state  in  CFG_W  engine switch-state result.
- frame_tick  in  1  frame-boundary pulse; commit point.
- cfg_active  out  CFG_W  live fabric configuration.
- cfg_pending  out  1  shadow holds an uncommitted configuration.
- cfg_owner  out  2  requester id of the last committed configuration.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  error cause: 1 = not a permutation, 2 = engine timeout; holds its value until the next error.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset values: FSM = IDLE; cfg_active = 0; cfg_pending = 0; cfg_owner = 0; eng_start = 0; eng_perm = 0; err_valid = 0; err_code = 0; round-robin pointer = 0; timeout counter = 0.
- FSM states and transitions:
  - IDLE -> CHECK on an accepted request.
  - CHECK (1 cycle) -> LAUNCH if the request is valid, else back to IDLE.
  - LAUNCH (1 cycle) -> WAIT.
  - WAIT -> IDLE on eng_done or on timeout.
- Arbitration:
  - Only in IDLE with cfg_pending = 0. req_ready is combinational and one-hot: it goes to the first valid requester at or after the pointer, wrapping.
  - On acceptance, the request is latched, the id is stored, and the pointer is set to granted+1 mod NREQ.
  - In any other state, or while cfg_pending = 1, req_ready = 0.
- Permutation check (CHECK state):
  - OR together the one-hot decode of all 8 entries; the result must equal 8'hFF.
  - On failure: err_valid = 1 for one cycle, err_code = 1, request dropped, return to IDLE.
  - The pointer has already advanced, so a faulty requester cannot starve the others.
- LAUNCH: eng_start = 1 for exactly one cycle; eng_perm is driven from the latched request; the timeout counter is cleared.
- WAIT:
  - The counter increments each cycle.
  - eng_done: shadow <= eng_state, cfg_pending <= 1, go to IDLE.
  - Counter reaches TIMEOUT without eng_done: err_valid pulse, err_code = 2, shadow untouched, go to IDLE.
  - eng_done in the same cycle the counter reaches TIMEOUT counts as done; no error.
  - eng_done outside WAIT is ignored.
- Commit:
  - frame_tick with cfg_pending = 1: cfg_active <= shadow, cfg_owner <= stored id, cfg_pending <= 0.
  - frame_tick with cfg_pending = 0: no effect.
  - frame_tick in the same cycle eng_done captures the shadow: no commit that cycle; the next frame_tick commits.
- Latency: acceptance to eng_start is 2 cycles. The earliest a new request can be accepted is the cycle after a commit.
- Reset mid-operation: all state returns to reset values immediately; an in-flight engine result is discarded.

Decomposition:
- Shared package benes8_pkg holds:
  - constants N_PORTS = 8, PERM_W = 24, CFG_W = 20;
  - FSM state encoding;
  - error-code constants ERR_NONE, ERR_PERM, ERR_TIMEOUT.
- One sub-module: benes8_rr_arb, the round-robin grant over NREQ with a pointer-update input.
- The permutation checker stays inline as a function in the package.

Test Plan:
- Reset check: assert areset mid-WAIT -> cfg_active = 0, busy = 0, eng_start = 0; with req0 valid, req_ready = 01 on the first cycle after release.
- Valid request, committed: req0 sends perm {7,6,5,4,3,2,1,0}, engine model returns 20'hA5A5A after 7 cycles -> eng_start at acceptance+2, cfg_pending = 1, cfg_active unchanged until frame_tick, then cfg_active = 20'hA5A5A and cfg_owner = 0.
- Invalid permutation: req1 sends perm {0,0,2,3,4,5,6,7} -> err_valid pulse with err_code = 1, no eng_start, cfg_pending stays 0.
- Engine timeout: engine never asserts eng_done -> err_code = 2 exactly TIMEOUT = 15 cycles after the WAIT counter is cleared, returns to IDLE, shadow and cfg_active unchanged.
- Fairness: both requesters hold valid continuously, frame_tick every 20 cycles -> grants alternate 0,1,0,1 and cfg_owner alternates in step.
- Simultaneous events: eng_done and frame_tick in the same cycle -> no commit that cycle, commit on the next frame_tick; eng_done on the TIMEOUT cycle -> no error, result captured.

Source files
------------

// File: rtl/benes8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : benes8_pkg
// Description : Shared constants, FSM encoding, error codes and the
//               permutation bijection check for the Benes-8 config scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package benes8_pkg;

    localparam int N_PORTS = 8;
    localparam int PERM_W  = 24;
    localparam int CFG_W   = 20;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_CHECK  = 2'd1;
    localparam logic [1:0] c_LAUNCH = 2'd2;
    localparam logic [1:0] c_WAIT   = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_PERM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Every output port must be hit exactly once: OR of one-hot decodes == all ones.
    function automatic logic perm_is_bijection(input logic [PERM_W-1:0] perm);
        logic [N_PORTS-1:0] hits;
        hits = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            hits[perm[3*k +: 3]] = 1'b1;
        end
        return (hits == {N_PORTS{1'b1}});
    endfunction

endpackage
`default_nettype wire

// File: rtl/benes8_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : benes8_rr_arb
// Description : Round-robin one-hot grant over NREQ requesters; the pointer
//               moves to granted+1 when the grant is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module benes8_rr_arb #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            areset,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic            upd,
    output logic [NREQ-1:0] grant,
    output logic [1:0]      grant_id
);

    localparam logic [1:0] c_LAST = 2'(NREQ - 1);

    logic [1:0]      r_ptr;
    logic [1:0]      w_id;
    logic [NREQ-1:0] w_grant;
    int              w_best;
    int              w_dist;

    // Pick the valid requester with the smallest wrapped distance from the pointer.
    always_comb begin
        w_id    = '0;
        w_best  = NREQ;
        w_dist  = 0;
        w_grant = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + NREQ - int'(r_ptr));
            if (req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_id   = 2'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            w_grant[j] = en && (w_best < NREQ) && (w_id == 2'(j));
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_ptr <= '0;
        end else if (upd) begin
            r_ptr <= (w_id == c_LAST) ? 2'd0 : (w_id + 2'd1);
        end
    end

    assign grant    = w_grant;
    assign grant_id = w_id;

endmodule
`default_nettype wire

// File: rtl/benes8_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module      : benes8_cfg_sched
// Description : Arbitrates permutation requests, validates them, runs the
//               Benes routing engine and commits its result on frame ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module benes8_cfg_sched
    import benes8_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15,
    parameter int CFG_W   = 20
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*PERM_W-1:0] req_perm,
    output logic [NREQ-1:0]        req_ready,
    output logic                   eng_start,
    output logic [PERM_W-1:0]      eng_perm,
    input  logic                   eng_done,
    input  logic [CFG_W-1:0]       eng_state,
    input  logic                   frame_tick,
    output logic [CFG_W-1:0]       cfg_active,
    output logic                   cfg_pending,
    output logic [1:0]             cfg_owner,
    output logic                   err_valid,
    output logic [1:0]             err_code,
    output logic                   busy
);

    localparam int                 c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [PERM_W-1:0]  r_req_perm;
    logic [1:0]         r_id;
    logic [PERM_W-1:0]  r_eng_perm;
    logic [c_CNT_W-1:0] r_cnt;
    logic [CFG_W-1:0]   r_shadow;
    logic [CFG_W-1:0]   r_cfg_active;
    logic               r_pending;
    logic [1:0]         r_owner;
    logic               r_err_valid;
    logic [1:0]         r_err_code;

    logic               w_arb_en;
    logic [NREQ-1:0]    w_grant;
    logic [1:0]         w_grant_id;
    logic               w_accept;
    logic [PERM_W-1:0]  w_sel_perm;
    logic               w_perm_ok;
    logic               w_timeout;
    logic [PERM_W-1:0]  w_perm_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_perm_slice
        assign w_perm_arr[g] = req_perm[g*PERM_W +: PERM_W];
    end

    // No new work while a result waits for its frame boundary.
    assign w_arb_en  = (r_state == c_IDLE) && !r_pending;
    assign w_accept  = |(req_valid & w_grant);
    assign w_perm_ok = perm_is_bijection(r_req_perm);
    assign w_timeout = ((int'(r_cnt) + 1) == TIMEOUT);

    benes8_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk      (clk),
        .areset   (areset),
        .req      (req_valid),
        .en       (w_arb_en),
        .upd      (w_accept),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

    always_comb begin
        w_sel_perm = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) w_sel_perm = w_perm_arr[i];
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_accept) w_state_nxt = c_CHECK;
            c_CHECK:  w_state_nxt = w_perm_ok ? c_LAUNCH : c_IDLE;
            c_LAUNCH: w_state_nxt = c_WAIT;
            c_WAIT:   if (eng_done || w_timeout) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_req_perm   <= '0;
            r_id         <= '0;
            r_eng_perm   <= '0;
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_cfg_active <= '0;
            r_pending    <= 1'b0;
            r_owner      <= '0;
            r_err_valid  <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_err_valid <= 1'b0;
            if (w_accept) begin
                r_req_perm <= w_sel_perm;
                r_id       <= w_grant_id;
            end
            if (r_state == c_CHECK) begin
                if (w_perm_ok) begin
                    r_eng_perm <= r_req_perm;
                end else begin
                    r_err_valid <= 1'b1;
                    r_err_code  <= ERR_PERM;
                end
            end
            if (r_state == c_LAUNCH) begin
                r_cnt <= '0;
            end
            // A done arriving on the final counted cycle still wins over the timeout.
            if (r_state == c_WAIT) begin
                r_cnt <= r_cnt + c_CNT_ONE;
                if (eng_done) begin
                    r_shadow  <= eng_state;
                    r_pending <= 1'b1;
                end else if (w_timeout) begin
                    r_err_valid <= 1'b1;
                    r_err_code  <= ERR_TIMEOUT;
                end
            end
            if (frame_tick && r_pending) begin
                r_cfg_active <= r_shadow;
                r_owner      <= r_id;
                r_pending    <= 1'b0;
            end
        end
    end

    assign req_ready   = w_grant;
    assign eng_start   = (r_state == c_LAUNCH);
    assign eng_perm    = r_eng_perm;
    assign cfg_active  = r_cfg_active;
    assign cfg_pending = r_pending;
    assign cfg_owner   = r_owner;
    assign err_valid   = r_err_valid;
    assign err_code    = r_err_code;
    assign busy        = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_benes8_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_benes8_cfg_sched
// Description : Directed, table-driven self-checking bench for benes8_cfg_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_benes8_cfg_sched;

    localparam int c_NREQ    = 2;
    localparam int c_TIMEOUT = 15;

    typedef struct {
        int          rid;
        logic [23:0] perm;
        int          dly;   // cycle in WAIT that eng_done fires; 0 = never
        logic [19:0] st;
        int          err;   // expected error code, 0 = commits
    } vec_t;

    logic                 clk;
    logic                 areset;
    logic [c_NREQ-1:0]    req_valid;
    logic [c_NREQ*24-1:0] req_perm;
    logic [c_NREQ-1:0]    req_ready;
    logic                 eng_start;
    logic [23:0]          eng_perm;
    logic                 eng_done;
    logic [19:0]          eng_state;
    logic                 frame_tick;
    logic [19:0]          cfg_active;
    logic                 cfg_pending;
    logic [1:0]           cfg_owner;
    logic                 err_valid;
    logic [1:0]           err_code;
    logic                 busy;

    int          n_tests;
    int          n_fail;
    logic [19:0] exp_cfg;
    logic [1:0]  exp_owner;

    benes8_cfg_sched #(
        .NREQ    (c_NREQ),
        .TIMEOUT (c_TIMEOUT),
        .CFG_W   (20)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .req_valid   (req_valid),
        .req_perm    (req_perm),
        .req_ready   (req_ready),
        .eng_start   (eng_start),
        .eng_perm    (eng_perm),
        .eng_done    (eng_done),
        .eng_state   (eng_state),
        .frame_tick  (frame_tick),
        .cfg_active  (cfg_active),
        .cfg_pending (cfg_pending),
        .cfg_owner   (cfg_owner),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_row(input vec_t v);
        logic [c_NREQ-1:0] e_rdy;
        int                n;
        e_rdy = '0;
        e_rdy[v.rid] = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        req_valid[v.rid] = 1'b1;
        req_perm[v.rid*24 +: 24] = v.perm;
        @(negedge clk);
        chk("row_ready", req_ready, e_rdy);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("row_check_busy", busy, 1);
        chk("row_check_nostart", eng_start, 0);
        @(posedge clk); #1;
        @(negedge clk);
        if (v.err == 1) begin
            chk("perm_err_valid", err_valid, 1);
            chk("perm_err_code", err_code, 1);
            chk("perm_nostart", eng_start, 0);
            chk("perm_idle", busy, 0);
            chk("perm_pending", cfg_pending, 0);
        end else begin
            chk("launch_start", eng_start, 1);
            chk("launch_perm", eng_perm, v.perm);
            n = (v.dly == 0) ? c_TIMEOUT : v.dly;
            for (int k = 1; k <= n; k++) begin
                @(posedge clk); #1;
                eng_done  = (k == v.dly);
                eng_state = v.st;
                @(negedge clk);
                if (k == 1) chk("wait_start_once", eng_start, 0);
                if (k == n) chk("wait_no_err_yet", err_valid, 0);
            end
            @(posedge clk); #1;
            eng_done = 1'b0;
            @(negedge clk);
            chk("end_idle", busy, 0);
            if (v.dly == 0) begin
                chk("timeout_err_valid", err_valid, 1);
                chk("timeout_err_code", err_code, v.err);
                chk("timeout_pending", cfg_pending, 0);
            end else begin
                chk("done_no_err", err_valid, 0);
                chk("done_pending", cfg_pending, 1);
                chk("done_cfg_held", cfg_active, exp_cfg);
            end
        end
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(negedge clk);
        chk("err_one_cycle", err_valid, 0);
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(negedge clk);
        if (v.err == 0) begin
            exp_cfg   = v.st;
            exp_owner = 2'(v.rid);
        end
        chk("tick_cfg", cfg_active, exp_cfg);
        chk("tick_owner", cfg_owner, exp_owner);
        chk("tick_pending", cfg_pending, 0);
    endtask

    initial begin
        vec_t        tbl [6];
        int          cd;
        int          exp_id;
        int          n_grants;
        logic        m_pend;
        logic        chk_next;
        logic [1:0]  m_owner;
        logic [1:0]  m_last;

        tbl[0] = '{rid: 0, perm: 24'hFAC688, dly: 7,  st: 20'hA5A5A, err: 0};
        tbl[1] = '{rid: 1, perm: 24'h013977, dly: 0,  st: 20'h00000, err: 1};
        tbl[2] = '{rid: 1, perm: 24'h053977, dly: 15, st: 20'h12345, err: 0};
        tbl[3] = '{rid: 0, perm: 24'hFAC688, dly: 0,  st: 20'hBADBA, err: 2};
        tbl[4] = '{rid: 1, perm: 24'h000000, dly: 0,  st: 20'h00000, err: 1};
        tbl[5] = '{rid: 0, perm: 24'h629EB4, dly: 1,  st: 20'hFFFFF, err: 0};

        n_tests    = 0;
        n_fail     = 0;
        exp_cfg    = '0;
        exp_owner  = '0;
        areset     = 1'b1;
        req_valid  = '0;
        req_perm   = '0;
        eng_done   = 1'b0;
        eng_state  = '0;
        frame_tick = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cfg", cfg_active, 0);
        chk("rst_pending", cfg_pending, 0);
        chk("rst_owner", cfg_owner, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_eng_perm", eng_perm, 0);
        chk("rst_ready", req_ready, 0);
        @(posedge clk); #1;
        areset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_row(tbl[i]);
        end

        // Reset while the engine is running.
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_perm  = {24'hFAC688, 24'hFAC688};
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        chk("midwait_busy_before", busy, 1);
        areset = 1'b1;
        #1;
        chk("midrst_cfg", cfg_active, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_start", eng_start, 0);
        chk("midrst_pending", cfg_pending, 0);
        chk("midrst_err_code", err_code, 0);
        @(posedge clk); #1;
        areset    = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        chk("midrst_ready_ptr0", req_ready, 2'b01);
        req_valid = '0;
        exp_cfg   = '0;
        exp_owner = '0;

        // Fairness: both requesters always valid, frame tick every 20 cycles.
        cd        = 0;
        exp_id    = 0;
        n_grants  = 0;
        m_pend    = 1'b0;
        chk_next  = 1'b0;
        m_owner   = '0;
        m_last    = '0;
        eng_state = 20'h0F0F0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(posedge clk); #1;
            req_valid  = (cyc < 80) ? 2'b11 : 2'b00;
            frame_tick = ((cyc % 20) == 19);
            eng_done   = (cd == 1);
            if (cd > 0) cd--;
            @(negedge clk);
            if (chk_next) begin
                chk("fair_owner", cfg_owner, m_owner);
                chk("fair_cfg", cfg_active, 20'h0F0F0);
                chk_next = 1'b0;
            end
            if (eng_start) cd = 3;
            if ((req_valid & req_ready) != '0) begin
                chk("fair_grant", req_ready[1], exp_id);
                m_last = req_ready[1] ? 2'd1 : 2'd0;
                exp_id = 1 - exp_id;
                n_grants++;
            end
            if (frame_tick && m_pend) begin
                m_owner  = m_last;
                m_pend   = 1'b0;
                chk_next = 1'b1;
            end
            if (eng_done) m_pend = 1'b1;
        end
        eng_done   = 1'b0;
        frame_tick = 1'b0;
        chk("fair_grant_count", n_grants, 4);
        chk("fair_final_owner", cfg_owner, 1);
        chk("fair_final_idle", busy, 0);

        // eng_done together with frame_tick: capture only, commit on the next tick.
        @(posedge clk); #1;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("sim_launch", eng_start, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        eng_done   = 1'b1;
        eng_state  = 20'h3C3C3;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        eng_done   = 1'b0;
        frame_tick = 1'b0;
        @(negedge clk);
        chk("sim_pending", cfg_pending, 1);
        chk("sim_cfg_held", cfg_active, 20'h0F0F0);
        chk("sim_owner_held", cfg_owner, 1);
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(negedge clk);
        chk("sim_commit_cfg", cfg_active, 20'h3C3C3);
        chk("sim_commit_owner", cfg_owner, 0);
        chk("sim_commit_pending", cfg_pending, 0);

        // eng_done while idle must not be captured.
        @(posedge clk); #1;
        eng_done  = 1'b1;
        eng_state = 20'h12345;
        @(posedge clk); #1;
        eng_done  = 1'b0;
        @(negedge clk);
        chk("idle_done_ignored", cfg_pending, 0);
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(negedge clk);
        chk("idle_done_cfg", cfg_active, 20'h3C3C3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
